data_memory_bytelane: RTL

Parametrised successor to the single-cycle MIPS data memory. It is a word-organised RAM with a valid/ready request handshake, configurable read/write latency, and byte/halfword/word access (lb/lbu/lh/lhu/lw/sb/sh/sw) with sign/zero extension. It flags misaligned and out-of-range accesses instead of corrupting memory. It sits behind the datapath's ALU address output and is usable by both the single-cycle and multi-cycle cores.

---
 rtl/data_memory_bytelane.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/data_memory_bytelane.sv
// Word-organised data RAM with byte/half/word loads and stores, sign/zero extension and error flags.
// Response LATENCY cycles after acceptance; req_ready drops while a request waits, one request per LATENCY cycles.
module data_memory_bytelane #(
   parameter int unsigned DEPTH     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h1000_1000,
   parameter int unsigned LATENCY   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic        resp_valid,
   output logic [31:0] read_data,
   output logic        err_misaligned,
   output logic        err_range
);
   localparam int unsigned AW     = $clog2(DEPTH);
   localparam logic [31:0] SPAN   = 32'(DEPTH * 4);
   localparam bit          DIRECT = (LATENCY == 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [31:0] mem [DEPTH];

   logic        cap_write, cap_uns;
   logic [1:0]  cap_size;
   logic [31:0] cap_addr, cap_wdata;

   logic        accept, commit;
   logic        op_write, op_uns;
   logic [1:0]  op_size, lane;
   logic [31:0] op_addr, op_wdata;
   logic [31:0] offset, word_rd, word_wr, load_val;
   logic [AW-1:0] idx;
   logic        op_mis, op_rng, op_err;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign req_ready = (state != WAIT);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      commit    = 1'b0;
      case (state)
         IDLE, RESP: begin
            state_nxt = IDLE;
            if (accept) begin
               if (DIRECT) begin
                  state_nxt = RESP;
                  commit    = 1'b1;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nxt = RESP;
               commit    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // With single-cycle latency the commit edge is the acceptance edge, so the live request is used.
   always_comb begin
      op_write = DIRECT ? req_write    : cap_write;
      op_size  = DIRECT ? req_size     : cap_size;
      op_uns   = DIRECT ? req_unsigned : cap_uns;
      op_addr  = DIRECT ? address      : cap_addr;
      op_wdata = DIRECT ? write_data   : cap_wdata;
   end

   always_comb begin
      offset = op_addr - BASE_ADDR;
      op_rng = (offset >= SPAN);
      idx    = offset[AW+1:2];
      lane   = op_addr[1:0];
      case (op_size)
         2'b00:   op_mis = 1'b0;
         2'b01:   op_mis = op_addr[0];
         2'b10:   op_mis = (op_addr[1:0] != 2'b00);
         default: op_mis = 1'b1;
      endcase
      op_err = op_mis || op_rng;
   end

   always_comb begin
      word_rd  = mem[idx];
      byte_sel = word_rd[{lane, 3'b000} +: 8];
      half_sel = word_rd[{lane[1], 4'b0000} +: 16];
      word_wr  = word_rd;
      load_val = word_rd;
      case (op_size)
         2'b00: begin
            word_wr[{lane, 3'b000} +: 8] = op_wdata[7:0];
            load_val = op_uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         2'b01: begin
            word_wr[{lane[1], 4'b0000} +: 16] = op_wdata[15:0];
            load_val = op_uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         2'b10:   word_wr = op_wdata;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         resp_valid     <= 1'b0;
         read_data      <= 32'd0;
         err_misaligned <= 1'b0;
         err_range      <= 1'b0;
         cap_write      <= 1'b0;
         cap_size       <= 2'b00;
         cap_uns        <= 1'b0;
         cap_addr       <= 32'd0;
         cap_wdata      <= 32'd0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         resp_valid <= commit;
         if (commit) begin
            read_data      <= (op_err || op_write) ? 32'd0 : load_val;
            err_misaligned <= op_mis;
            err_range      <= op_rng;
         end
         if (accept) begin
            cap_write <= req_write;
            cap_size  <= req_size;
            cap_uns   <= req_unsigned;
            cap_addr  <= address;
            cap_wdata <= write_data;
         end
      end
   end

   // Array is deliberately not reset; errored stores never reach it.
   always_ff @(posedge clk) begin
      if (rst_n && commit && op_write && !op_err)
         mem[idx] <= word_wr;
   end
endmodule
